// File: rtl/hilo_div_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hilo_div_ctrl_pkg                                            |
// | Description : Shared types and constants for the HI/LO divide controller:  |
// |               operation encodings, FSM state enum, default datapath width  |
// |               and the divide-by-zero LO fill value.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package hilo_div_ctrl_pkg;

    // Datapath width shared by the controller and the divider it drives
    localparam int DEF_WIDTH = 32;

    // HI/LO-class operation encodings as presented by EX
    localparam logic [1:0] OP_DIVU = 2'd0;
    localparam logic [1:0] OP_DIV  = 2'd1;
    localparam logic [1:0] OP_MTHI = 2'd2;
    localparam logic [1:0] OP_MTLO = 2'd3;

    // On a zero divisor every LO bit is set to this value (LO = all ones)
    localparam logic DIV0_LO_FILL = 1'b1;

    // Controller FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/hilo_div_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hilo_div_ctrl_if                                             |
// | Description : Start/busy handshake between the HI/LO controller (master)   |
// |               and the iterative unsigned divider (slave).                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface hilo_div_ctrl_if
    import hilo_div_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             div_start;
    logic [WIDTH-1:0] div_dividend;
    logic [WIDTH-1:0] div_divisor;
    logic             div_busy;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;

    modport master (
        output div_start,
        output div_dividend,
        output div_divisor,
        input  div_busy,
        input  div_q,
        input  div_r
    );

    modport slave (
        input  div_start,
        input  div_dividend,
        input  div_divisor,
        output div_busy,
        output div_q,
        output div_r
    );
endinterface
`default_nettype wire

// File: rtl/hilo_div_ctrl_div_sign_fix.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hilo_div_ctrl_div_sign_fix                                   |
// | Description : Combinational conditional two's-complement negate. Used both |
// |               to turn signed operands into magnitudes and to re-apply the  |
// |               sign to the unsigned quotient/remainder.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hilo_div_ctrl_div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);
    // Negation wraps, so the most negative value maps onto itself
    assign result = negate ? ((~value) + WIDTH'(1)) : value;
endmodule
`default_nettype wire

// File: rtl/hilo_div_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hilo_div_ctrl                                                |
// | Description : EX-stage requester for the iterative divider. Accepts        |
// |               DIV/DIVU/MTHI/MTLO, launches the divider, stalls the pipe    |
// |               until the result is back, corrects signs and owns HI/LO.     |
// |               Build option: DIV_SIGNED_EN - when defined, op DIV performs  |
// |               signed division; otherwise DIV behaves exactly like DIVU.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hilo_div_ctrl
    import hilo_div_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ITER  = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             op_valid,
    input  wire logic [1:0]       op,
    input  wire logic [WIDTH-1:0] rs_val,
    input  wire logic [WIDTH-1:0] rt_val,
    input  wire logic             flush,
    output logic                  stall,
    output logic [WIDTH-1:0]      hi,
    output logic [WIDTH-1:0]      lo,
    hilo_div_ctrl_if.master       div
);

    // Watchdog bound: a divide or a drain never keeps us out of IDLE longer than this
    localparam int               WD_W     = $clog2(ITER + 8) + 1;
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(ITER + 4);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic             r_q_neg;
    logic             r_r_neg;
    logic [WD_W-1:0]  r_wd_cnt;

    logic             w_is_div;
    logic             w_rt_zero;
    logic             w_rs_neg;
    logic             w_rt_neg;
    logic [WIDTH-1:0] w_rs_mag;
    logic [WIDTH-1:0] w_rt_mag;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    logic             w_stall;
    logic             w_start;
    logic             w_accept;
    logic             w_capture;
    logic             w_div0;
    logic             w_mthi;
    logic             w_mtlo;

    assign w_is_div  = (op == OP_DIVU) || (op == OP_DIV);
    assign w_rt_zero = (rt_val == '0);

`ifdef DIV_SIGNED_EN
    // Only DIV looks at operand signs; DIVU operands are already magnitudes
    assign w_rs_neg = (op == OP_DIV) && rs_val[WIDTH-1];
    assign w_rt_neg = (op == OP_DIV) && rt_val[WIDTH-1];
`else
    // Unsigned-only build: DIV is a DIVU, operands pass straight through
    assign w_rs_neg = 1'b0;
    assign w_rt_neg = 1'b0;
`endif

    hilo_div_ctrl_div_sign_fix #(.WIDTH(WIDTH)) u_fix_rs (
        .value  (rs_val),
        .negate (w_rs_neg),
        .result (w_rs_mag)
    );

    hilo_div_ctrl_div_sign_fix #(.WIDTH(WIDTH)) u_fix_rt (
        .value  (rt_val),
        .negate (w_rt_neg),
        .result (w_rt_mag)
    );

    hilo_div_ctrl_div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (
        .value  (div.div_q),
        .negate (r_q_neg),
        .result (w_q_fix)
    );

    hilo_div_ctrl_div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (
        .value  (div.div_r),
        .negate (r_r_neg),
        .result (w_r_fix)
    );

    // Next-state, stall, start pulse and HI/LO write enables
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_start     = 1'b0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_div0      = 1'b0;
        w_mthi      = 1'b0;
        w_mtlo      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (op_valid) begin
                    if (w_is_div) begin
                        if (w_rt_zero) begin
                            w_div0 = 1'b1;
                        end else begin
                            w_accept    = 1'b1;
                            w_stall     = 1'b1;
                            w_state_nxt = ST_START;
                        end
                    end else if (op == OP_MTHI) begin
                        w_mthi = 1'b1;
                    end else begin
                        w_mtlo = 1'b1;
                    end
                end
            end
            ST_START: begin
                w_stall     = 1'b1;
                w_start     = 1'b1;
                w_state_nxt = flush ? ST_DRAIN : ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                w_stall = 1'b1;
                if (flush) begin
                    w_state_nxt = ST_DRAIN;
                end else if (div.div_busy) begin
                    w_state_nxt = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                w_stall = 1'b1;
                // Flush beats a coincident busy-fall; if busy is already low there is nothing to drain
                if (flush) begin
                    w_state_nxt = div.div_busy ? ST_DRAIN : ST_IDLE;
                end else if (!div.div_busy) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                w_stall = 1'b1;
                if (!div.div_busy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand magnitudes and result sign flags, latched when a divide is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dividend <= '0;
            r_divisor  <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
        end else if (w_accept) begin
            r_dividend <= w_rs_mag;
            r_divisor  <= w_rt_mag;
            r_q_neg    <= w_rs_neg ^ w_rt_neg;
            r_r_neg    <= w_rs_neg;
        end
    end

    // Architectural HI/LO: divide result, divide-by-zero result or MTHI/MTLO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (w_capture) begin
            hi <= w_r_fix;
            lo <= w_q_fix;
        end else if (w_div0) begin
            hi <= rs_val;
            lo <= {WIDTH{DIV0_LO_FILL}};
        end else if (w_mthi) begin
            hi <= rs_val;
        end else if (w_mtlo) begin
            lo <= rs_val;
        end
    end

    // Watchdog: count cycles spent outside IDLE and flag a divider that never finishes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd_cnt <= '0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_wd_cnt <= '0;
            end else if (r_wd_cnt != {WD_W{1'b1}}) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            assert (r_wd_cnt <= WD_LIMIT);
        end
    end

    assign stall            = w_stall;
    assign div.div_start    = w_start;
    assign div.div_dividend = r_dividend;
    assign div.div_divisor  = r_divisor;

endmodule
`default_nettype wire

// File: tb/tb_hilo_div_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hilo_div_ctrl                                             |
// | Description : Directed self-checking bench for hilo_div_ctrl with a        |
// |               behavioural 32-iteration divider on the slave side.          |
// |               Expected signed results follow DIV_SIGNED_EN.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_hilo_div_ctrl;
    import hilo_div_ctrl_pkg::*;

    localparam int ITER = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    int dcnt;

    hilo_div_ctrl_if #(.WIDTH(32)) dif ();

    hilo_div_ctrl #(.WIDTH(32), .ITER(ITER)) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .op       (op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .flush    (flush),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo),
        .div      (dif)
    );

    always #5 clk = ~clk;

    // Divider model: samples start on negedge, busy high for ITER negedges
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            dif.div_busy <= 1'b0;
            dif.div_q    <= '0;
            dif.div_r    <= '0;
            dcnt         <= 0;
        end else if (!dif.div_busy && dif.div_start) begin
            dif.div_busy <= 1'b1;
            dif.div_q    <= dif.div_dividend / dif.div_divisor;
            dif.div_r    <= dif.div_dividend % dif.div_divisor;
            dcnt         <= ITER;
        end else if (dif.div_busy) begin
            if (dcnt == 1) dif.div_busy <= 1'b0;
            dcnt <= dcnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one divide from its accept cycle until stall drops; fcyc < 0 means no flush
    task automatic do_div(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int fcyc,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        int nst;
        int nstart;
        int scyc;
        cyc = 0; nst = 0; nstart = 0; scyc = -1;
        op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
        while (1) begin
            flush = (cyc == fcyc);
            #1;
            if (cyc > 0 && !stall) break;
            if (cyc >= 80) break;
            if (stall) nst++;
            if (dif.div_start) begin
                nstart++;
                scyc = cyc;
            end
            if (fcyc >= 0 && cyc == fcyc + 1)
                chk({tag, "_drain"}, 32'(dut.r_state), 32'(ST_DRAIN));
            @(posedge clk); #1;
            op_valid = 1'b0;
            cyc++;
        end
        flush = 1'b0;
        chk({tag, "_idle_cycle"}, cyc, 34);
        chk({tag, "_stall_cycles"}, nst, 34);
        chk({tag, "_start_pulses"}, nstart, 1);
        chk({tag, "_start_cycle"}, scyc, 1);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_start", {31'b0, dif.div_start}, 32'h0);
        chk("rst_dividend", dif.div_dividend, 32'h0);
        chk("rst_divisor", dif.div_divisor, 32'h0);

        // Unsigned divide, then back-to-back signed cases
        do_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, -1, 32'd2, 32'd14);
`ifdef DIV_SIGNED_EN
        do_div("div_m100_7", OP_DIV, 32'hFFFFFF9C, 32'd7, -1, 32'hFFFFFFFE, 32'hFFFFFFF2);
        do_div("div_100_m7", OP_DIV, 32'd100, 32'hFFFFFFF9, -1, 32'd2, 32'hFFFFFFF2);
        do_div("div_min_m1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, -1, 32'h0, 32'h80000000);
`else
        do_div("div_m100_7", OP_DIV, 32'hFFFFFF9C, 32'd7, -1, 32'd2, 32'h24924916);
        do_div("div_100_m7", OP_DIV, 32'd100, 32'hFFFFFFF9, -1, 32'd100, 32'h0);
        do_div("div_min_m1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, -1, 32'h80000000, 32'h0);
`endif

        // Divide by zero: single cycle, no launch, no stall
        op_valid = 1'b1; op = OP_DIVU; rs_val = 32'd5; rt_val = 32'd0;
        #1;
        chk("div0_stall", {31'b0, stall}, 32'h0);
        @(posedge clk); #1;
        chk("div0_start", {31'b0, dif.div_start}, 32'h0);
        chk("div0_hi", hi, 32'd5);
        chk("div0_lo", lo, 32'hFFFFFFFF);
        op = OP_DIV; rs_val = 32'hFFFFFFFB;
        #1;
        chk("div0s_stall", {31'b0, stall}, 32'h0);
        @(posedge clk); #1;
        op_valid = 1'b0;
        #1;
        chk("div0s_state", 32'(dut.r_state), 32'(ST_IDLE));
        chk("div0s_hi", hi, 32'hFFFFFFFB);
        chk("div0s_lo", lo, 32'hFFFFFFFF);

        // MTHI then MTLO on consecutive cycles
        op_valid = 1'b1; op = OP_MTHI; rs_val = 32'hDEADBEEF;
        #1;
        chk("mthi_stall", {31'b0, stall}, 32'h0);
        @(posedge clk); #1;
        op = OP_MTLO; rs_val = 32'h12345678;
        #1;
        chk("mtlo_stall", {31'b0, stall}, 32'h0);
        chk("mthi_hi", hi, 32'hDEADBEEF);
        @(posedge clk); #1;
        op_valid = 1'b0;
        #1;
        chk("mt_hi", hi, 32'hDEADBEEF);
        chk("mt_lo", lo, 32'h12345678);

        // Flush mid-divide, and flush coinciding with busy-fall
        do_div("flush10", OP_DIVU, 32'd100, 32'd7, 10, 32'hDEADBEEF, 32'h12345678);
        do_div("flush33", OP_DIVU, 32'd50, 32'd3, 33, 32'hDEADBEEF, 32'h12345678);

        // Dividend smaller than divisor, then a plain divide
        do_div("divu_7_100", OP_DIVU, 32'd7, 32'd100, -1, 32'd7, 32'd0);
        do_div("divu_1000_7", OP_DIVU, 32'd1000, 32'd7, -1, 32'd6, 32'd142);

        // Asynchronous reset in cycle 15 of a divide
        op_valid = 1'b1; op = OP_DIVU; rs_val = 32'd1000; rt_val = 32'd3;
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (14) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_hi", hi, 32'h0);
        chk("arst_lo", lo, 32'h0);
        chk("arst_stall", {31'b0, stall}, 32'h0);
        chk("arst_state", 32'(dut.r_state), 32'(ST_IDLE));
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        do_div("divu_9_3", OP_DIVU, 32'd9, 32'd3, -1, 32'd0, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "time limit reached");
    end

endmodule
`default_nettype wire
